// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: opcodes, FSM states and
// the bit-reverse helper used to build left/rotate forms from right shifts.
package shift_sequencer_pkg;

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_STEP = 2'b01,
        ST_FIN  = 2'b10
    } state_t;

    function automatic logic [7:0] bit_reverse(input logic [7:0] value);
        logic [7:0] flipped;
        for (int i = 0; i < 8; i++) begin
            flipped[i] = value[7 - i];
        end
        return flipped;
    endfunction

endpackage

// File: rtl/barrel_shifter_8bit.sv
// 8-bit logical-right barrel shifter, zero fill, shift 0-7 set by ctrl.
// Built as three conditional stages (by 1, 2 and 4).
module barrel_shifter_8bit (
    input  logic [7:0] data,
    input  logic [2:0] ctrl,
    output logic [7:0] result
);

    logic [7:0] stage1;
    logic [7:0] stage2;

    assign stage1 = ctrl[0] ? {1'b0, data[7:1]}     : data;
    assign stage2 = ctrl[1] ? {2'b00, stage1[7:2]}  : stage1;
    assign result = ctrl[2] ? {4'h0, stage2[7:4]}   : stage2;

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer around a single right barrel shifter.
// Left, arithmetic and rotate forms reuse the right shifter through
// bit-reversal and inversion of the operand before and after shifting.
module shift_sequencer
    import shift_sequencer_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       START,
    input  logic [1:0] OPCODE,
    input  logic [7:0] DATA,
    input  logic [7:0] AMOUNT,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RESULT
);

    state_t     state;
    logic [1:0] op;
    logic [7:0] acc;
    logic [7:0] tmp;
    logic [7:0] operand;
    logic [3:0] rem;
    logic [2:0] rot_k;
    logic       sign_flip;
    logic       ror_second;

    logic [7:0] sh_in;
    logic [7:0] sh_out;
    logic [2:0] sh_ctrl;
    logic [2:0] chunk;
    logic [3:0] rem_next;
    logic [7:0] acc_init;
    logic [7:0] post_out;

    barrel_shifter_8bit u_shifter (
        .data   (sh_in),
        .ctrl   (sh_ctrl),
        .result (sh_out)
    );

    // Select shifter operand/amount and form the pre- and post-transforms.
    always_comb begin
        chunk    = (rem > 4'd7) ? 3'd7 : rem[2:0];
        rem_next = rem - {1'b0, chunk};
        sh_in    = acc;
        sh_ctrl  = chunk;
        if (op == OP_ROR) begin
            if (ror_second) begin
                sh_in   = bit_reverse(operand);
                sh_ctrl = 3'd0 - rot_k;
            end else begin
                sh_in   = operand;
                sh_ctrl = rot_k;
            end
        end

        case (OPCODE)
            OP_SLL:  acc_init = bit_reverse(DATA);
            OP_SRA:  acc_init = DATA[7] ? ~DATA : DATA;
            OP_SRL:  acc_init = DATA;
            default: acc_init = DATA;
        endcase

        case (op)
            OP_SLL:  post_out = bit_reverse(sh_out);
            OP_SRA:  post_out = sign_flip ? ~sh_out : sh_out;
            default: post_out = sh_out;
        endcase
    end

    // Sequencer FSM: capture request, run shift steps, pulse DONE once.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            op         <= OP_SRL;
            acc        <= 8'h00;
            tmp        <= 8'h00;
            operand    <= 8'h00;
            rem        <= 4'd0;
            rot_k      <= 3'd0;
            sign_flip  <= 1'b0;
            ror_second <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            RESULT     <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        state      <= ST_STEP;
                        BUSY       <= 1'b1;
                        op         <= OPCODE;
                        operand    <= DATA;
                        acc        <= acc_init;
                        rot_k      <= AMOUNT[2:0];
                        rem        <= (AMOUNT >= 8'd8) ? 4'd8 : AMOUNT[3:0];
                        sign_flip  <= (OPCODE == OP_SRA) && DATA[7];
                        ror_second <= 1'b0;
                    end
                end
                ST_STEP: begin
                    if (op == OP_ROR) begin
                        if (!ror_second) begin
                            tmp <= sh_out;
                            if (rot_k == 3'd0) begin
                                RESULT <= sh_out;
                                DONE   <= 1'b1;
                                state  <= ST_FIN;
                            end else begin
                                ror_second <= 1'b1;
                            end
                        end else begin
                            RESULT <= tmp | bit_reverse(sh_out);
                            DONE   <= 1'b1;
                            state  <= ST_FIN;
                        end
                    end else begin
                        acc <= sh_out;
                        rem <= rem_next;
                        if (rem_next == 4'd0) begin
                            RESULT <= post_out;
                            DONE   <= 1'b1;
                            state  <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: requests push the expected result
// and DONE cycle; an independent monitor checks every DONE pulse.
module tb_shift_sequencer;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       START;
    logic [1:0] OPCODE;
    logic [7:0] DATA;
    logic [7:0] AMOUNT;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RESULT;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit prevDone = 1'b0;

    typedef struct {
        logic [7:0] res;
        int         doneCyc;
        string      name;
    } exp_t;

    exp_t sb[$];

    shift_sequencer dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .START   (START),
        .OPCODE  (OPCODE),
        .DATA    (DATA),
        .AMOUNT  (AMOUNT),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .RESULT  (RESULT)
    );

    // Free-running clock, period 10.
    always #5 CLK = ~CLK;

    // Reference result straight from the operation definitions.
    function automatic logic [7:0] refResult(input logic [1:0] op, input logic [7:0] d,
                                             input logic [7:0] a);
        int               n;
        logic signed [7:0] s;
        logic [7:0]       r;
        logic [15:0]      w;
        n = (a > 8'd8) ? 8 : int'(a);
        r = 8'h00;
        case (op)
            2'b00: r = (n >= 8) ? 8'h00 : d >> n;
            2'b01: r = (n >= 8) ? 8'h00 : d << n;
            2'b10: begin
                s = d;
                s = s >>> ((n > 7) ? 7 : n);
                r = s;
            end
            default: begin
                w = {d, d} >> (int'(a) % 8);
                r = w[7:0];
            end
        endcase
        return r;
    endfunction

    // Number of STEP cycles the operation should take.
    function automatic int refSteps(input logic [1:0] op, input logic [7:0] a);
        if (op == 2'b11) return (a[2:0] == 3'd0) ? 1 : 2;
        return (a >= 8'd8) ? 2 : 1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Called at a negedge with the DUT idle; START is sampled at the next edge.
    // junkMode: 0 = START low while busy, 1 = random START, 2 = START every cycle.
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] d,
                                 input logic [7:0] a, input string name, input int junkMode);
        exp_t e;
        int   s;
        s         = refSteps(op, a);
        e.res     = refResult(op, d, a);
        e.doneCyc = cyc + 1 + s;
        e.name    = name;
        sb.push_back(e);
        START  = 1'b1;
        OPCODE = op;
        DATA   = d;
        AMOUNT = a;
        @(negedge CLK);
        for (int i = 0; i <= s; i++) begin
            checkOutput({name, "_busy"}, int'(BUSY), 1);
            START  = (junkMode == 2) ? 1'b1 : (junkMode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            OPCODE = 2'($urandom);
            DATA   = 8'($urandom);
            AMOUNT = 8'($urandom);
            @(negedge CLK);
        end
        START = 1'b0;
        checkOutput({name, "_idle_busy"}, int'(BUSY), 0);
        checkOutput({name, "_hold"}, int'(RESULT), int'(e.res));
    endtask

    // Monitor: on each DONE, pop the oldest expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            if (DONE === 1'b1) begin
                checkOutput("done_width", int'(prevDone), 0);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL spurious_done actual=DONE expected=no_DONE cycle=%0d", cyc);
                end else begin
                    e = sb.pop_front();
                    checkOutput({e.name, "_result"}, int'(RESULT), int'(e.res));
                    checkOutput({e.name, "_done_cycle"}, cyc, e.doneCyc);
                end
            end
            prevDone = (DONE === 1'b1);
        end
    end

    // Main stimulus: reset, directed cases, START storm, mid-op reset, random.
    initial begin
        logic [7:0] ra;
        RESET_N = 1'b0;
        START   = 1'b0;
        OPCODE  = 2'b00;
        DATA    = 8'h00;
        AMOUNT  = 8'h00;
        repeat (2) @(negedge CLK);
        checkOutput("reset_busy", int'(BUSY), 0);
        checkOutput("reset_done", int'(DONE), 0);
        checkOutput("reset_result", int'(RESULT), 0);
        RESET_N = 1'b1;
        @(negedge CLK);

        applyStimulus(2'b00, 8'h80, 8'd3,   "srl_80_3",   0);
        applyStimulus(2'b01, 8'h81, 8'd1,   "sll_81_1",   0);
        applyStimulus(2'b01, 8'hFF, 8'd8,   "sll_ff_8",   0);
        applyStimulus(2'b10, 8'h90, 8'd2,   "sra_90_2",   0);
        applyStimulus(2'b10, 8'h90, 8'd200, "sra_90_200", 0);
        applyStimulus(2'b10, 8'h70, 8'd255, "sra_70_255", 0);
        applyStimulus(2'b11, 8'hB1, 8'd3,   "ror_b1_3",   0);
        applyStimulus(2'b11, 8'hB1, 8'd8,   "ror_b1_8",   0);
        applyStimulus(2'b00, 8'hA5, 8'd0,   "srl_a5_0",   0);
        applyStimulus(2'b00, 8'h80, 8'd8,   "srl_storm",  2);
        applyStimulus(2'b00, 8'hC3, 8'd7,   "srl_c3_7",   2);
        applyStimulus(2'b11, 8'h01, 8'd1,   "ror_01_1",   0);

        START   = 1'b1;
        OPCODE  = 2'b10;
        DATA    = 8'h90;
        AMOUNT  = 8'd9;
        @(negedge CLK);
        checkOutput("abort_busy_step", int'(BUSY), 1);
        START   = 1'b0;
        RESET_N = 1'b0;
        @(negedge CLK);
        checkOutput("abort_busy", int'(BUSY), 0);
        checkOutput("abort_done", int'(DONE), 0);
        checkOutput("abort_result", int'(RESULT), 0);
        RESET_N = 1'b1;
        repeat (6) @(negedge CLK);
        applyStimulus(2'b00, 8'h40, 8'd1, "srl_40_1", 0);

        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            applyStimulus(2'($urandom), 8'($urandom), ra, $sformatf("rand%0d", i), 1);
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        repeat (4) @(negedge CLK);
        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
